// File: rtl/cobs_pkg.sv
// Shared COBS constants and types used by both the encoder and the decoder.
package cobs_pkg;

    localparam logic [7:0] COBS_DELIM    = 8'h00;
    localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

    typedef enum logic [1:0] {
        CODE,
        DATA,
        DISCARD
    } cobs_dec_state_t;

    // A full-length block (0xFF) is followed by another code byte, not by a zero.
    function automatic logic cobs_owes_zero(input logic [7:0] code);
        return code != COBS_MAX_CODE;
    endfunction

endpackage

// File: rtl/axis_adapter_cobs_decoder_if.sv
// Byte-stream bundle around the COBS decoder: encoded input, decoded output, error pulse.
interface axis_adapter_cobs_decoder_if;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;

    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;

    logic       frame_error;

    // master: the environment feeding encoded bytes and consuming decoded ones.
    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast,
        input  m_axis_tuser,
        input  frame_error
    );

    // slave: the decoder itself.
    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast,
        output m_axis_tuser,
        output frame_error
    );

endinterface

// File: rtl/axis_adapter_cobs_decoder.sv
// COBS frame decoder: 0x00-delimited encoded bytes in, decoded AXI-Stream bytes out.
// A one-byte holdback register lets tlast/tuser be known when each byte is emitted.
module axis_adapter_cobs_decoder
    import cobs_pkg::*;
#(
    parameter int unsigned MAX_FRAME_LEN = 256
) (
    input logic                        clk,
    input logic                        reset,
    axis_adapter_cobs_decoder_if.slave bus
);

    localparam int unsigned      LEN_W   = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_FRAME_LEN);

    cobs_dec_state_t  r_state;
    logic [7:0]       r_count;
    logic             r_zero_owed;
    logic [7:0]       r_pend;
    logic             r_pend_valid;
    logic [LEN_W-1:0] r_len;

    logic [7:0]       r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic             r_m_user;
    logic             r_frame_error;

    cobs_dec_state_t  w_state_nxt;
    logic [7:0]       w_count_nxt;
    logic             w_zero_owed_nxt;
    logic [7:0]       w_pend_nxt;
    logic             w_pend_valid_nxt;
    logic [LEN_W-1:0] w_len_nxt;

    logic             w_s_ready;
    logic             w_take;
    logic             w_push;
    logic [7:0]       w_push_data;
    logic             w_emit;
    logic             w_emit_last;
    logic             w_emit_user;
    logic             w_err;

    // Accept only when the output slot is free or draining this cycle.
    assign w_s_ready = reset && (!r_m_valid || bus.m_axis_tready);
    assign w_take    = bus.s_axis_tvalid && w_s_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_zero_owed_nxt  = r_zero_owed;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_len_nxt        = r_len;
        w_push           = 1'b0;
        w_push_data      = COBS_DELIM;
        w_emit           = 1'b0;
        w_emit_last      = 1'b0;
        w_emit_user      = 1'b0;
        w_err            = 1'b0;

        if (w_take) begin
            case (r_state)
                CODE: begin
                    if (bus.s_axis_tdata == COBS_DELIM) begin
                        w_emit           = r_pend_valid;
                        w_emit_last      = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                        w_zero_owed_nxt  = 1'b0;
                        w_len_nxt        = '0;
                    end else begin
                        w_push          = r_zero_owed;
                        w_push_data     = COBS_DELIM;
                        w_count_nxt     = bus.s_axis_tdata - 8'd1;
                        w_zero_owed_nxt = cobs_owes_zero(bus.s_axis_tdata);
                        w_state_nxt     = (bus.s_axis_tdata == 8'd1) ? CODE : DATA;
                    end
                end
                DATA: begin
                    if (bus.s_axis_tdata == COBS_DELIM) begin
                        // Delimiter inside a block: the frame was cut short.
                        w_emit           = r_pend_valid;
                        w_emit_last      = 1'b1;
                        w_emit_user      = 1'b1;
                        w_pend_valid_nxt = 1'b0;
                        w_err            = 1'b1;
                        w_zero_owed_nxt  = 1'b0;
                        w_len_nxt        = '0;
                        w_state_nxt      = CODE;
                    end else begin
                        w_push      = 1'b1;
                        w_push_data = bus.s_axis_tdata;
                        w_count_nxt = r_count - 8'd1;
                        if (r_count == 8'd1) begin
                            w_state_nxt = CODE;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.s_axis_tdata == COBS_DELIM) begin
                        w_state_nxt = CODE;
                    end
                end
                default: w_state_nxt = CODE;
            endcase
        end

        if (w_push) begin
            if (r_len == LEN_MAX) begin
                // Overlength: close the frame on the held byte and drop the rest.
                w_emit           = r_pend_valid;
                w_emit_last      = 1'b1;
                w_emit_user      = 1'b1;
                w_pend_valid_nxt = 1'b0;
                w_err            = 1'b1;
                w_zero_owed_nxt  = 1'b0;
                w_len_nxt        = '0;
                w_state_nxt      = DISCARD;
            end else begin
                w_emit           = r_pend_valid;
                w_pend_nxt       = w_push_data;
                w_pend_valid_nxt = 1'b1;
                w_len_nxt        = r_len + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CODE;
            r_count      <= 8'd0;
            r_zero_owed  <= 1'b0;
            r_pend       <= 8'd0;
            r_pend_valid <= 1'b0;
            r_len        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_zero_owed  <= w_zero_owed_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_len        <= w_len_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_data      <= 8'd0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_user      <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_err;
            if (w_emit) begin
                r_m_data  <= r_pend;
                r_m_last  <= w_emit_last;
                r_m_user  <= w_emit_user;
                r_m_valid <= 1'b1;
            end else if (bus.m_axis_tready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = w_s_ready;
    assign bus.m_axis_tdata  = r_m_data;
    assign bus.m_axis_tvalid = r_m_valid;
    assign bus.m_axis_tlast  = r_m_last;
    assign bus.m_axis_tuser  = r_m_user;
    assign bus.frame_error   = r_frame_error;

endmodule

// File: tb/tb_axis_adapter_cobs_decoder.sv
// Bench for the COBS decoder: two instances (256- and 4-byte frame limits) fed by directed
// and random frames; a frame-level reference decoder fills per-instance expected queues.
module tb_axis_adapter_cobs_decoder;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] s_data  [2];
    logic       s_valid [2];
    logic       s_ready [2];
    logic [7:0] m_data  [2];
    logic       m_valid [2];
    logic       m_ready [2];
    logic       m_last  [2];
    logic       m_user  [2];
    logic       ferr    [2];
    bit         rnd_rdy [2];
    bit         rnd_val [2];
    int         exp_err [2];
    int         got_err [2];

    beat_t q0[$];
    beat_t q1[$];
    int checks = 0;
    int errors = 0;

    function automatic int max_len(input int g);
        return (g == 0) ? 256 : 4;
    endfunction

    function automatic void exp_push(input int g, input beat_t b);
        if (g == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    function automatic int exp_size(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endfunction

    function automatic void check_beat(input int g);
        beat_t got;
        beat_t want;
        got = '{d: m_data[g], l: m_last[g], u: m_user[g]};
        checks++;
        if (exp_size(g) == 0) begin
            errors++;
            $display("FAIL dut%0d unexpected beat got d=%h last=%b user=%b want none",
                     g, got.d, got.l, got.u);
        end else begin
            want = (g == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL dut%0d beat got d=%h last=%b user=%b want d=%h last=%b user=%b",
                         g, got.d, got.l, got.u, want.d, want.l, want.u);
            end
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_adapter_cobs_decoder_if bus ();

        axis_adapter_cobs_decoder #(
            .MAX_FRAME_LEN((g == 0) ? 256 : 4)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );

        assign bus.s_axis_tdata  = s_data[g];
        assign bus.s_axis_tvalid = s_valid[g];
        assign bus.m_axis_tready = m_ready[g];
        assign s_ready[g]        = bus.s_axis_tready;
        assign m_data[g]         = bus.m_axis_tdata;
        assign m_valid[g]        = bus.m_axis_tvalid;
        assign m_last[g]         = bus.m_axis_tlast;
        assign m_user[g]         = bus.m_axis_tuser;
        assign ferr[g]           = bus.frame_error;

        always @(posedge clk) m_ready[g] <= rnd_rdy[g] ? 1'($urandom_range(0, 1)) : 1'b1;

        always @(negedge clk) begin
            if (reset === 1'b1 && m_valid[g] === 1'b1 && m_ready[g] === 1'b1) check_beat(g);
            if (reset === 1'b1 && ferr[g] === 1'b1) got_err[g]++;
        end
    end

    // Reference: walk the frame block by block, then apply the length limit.
    function automatic void ref_decode(input bq_t enc, input int maxlen, output bq_t out,
                                       output bit bad);
        int i = 0;
        int n = enc.size();
        int code;
        out.delete();
        bad = 1'b0;
        while (i < n) begin
            code = int'(enc[i]);
            i++;
            if (i + code - 1 > n) begin
                bad = 1'b1;
                while (i < n) begin
                    out.push_back(enc[i]);
                    i++;
                end
            end else begin
                for (int k = 0; k < code - 1; k++) begin
                    out.push_back(enc[i]);
                    i++;
                end
                if (code != 255 && i < n) out.push_back(8'h00);
            end
        end
        if (out.size() > maxlen) begin
            bad = 1'b1;
            while (out.size() > maxlen) void'(out.pop_back());
        end
    endfunction

    function automatic void cobs_encode(input bq_t pl, output bq_t enc);
        bq_t blk;
        enc.delete();
        foreach (pl[i]) begin
            if (pl[i] == 8'h00) begin
                enc.push_back(8'(blk.size() + 1));
                foreach (blk[k]) enc.push_back(blk[k]);
                blk.delete();
            end else begin
                blk.push_back(pl[i]);
                if (blk.size() == 254) begin
                    enc.push_back(8'hFF);
                    foreach (blk[k]) enc.push_back(blk[k]);
                    blk.delete();
                end
            end
        end
        enc.push_back(8'(blk.size() + 1));
        foreach (blk[k]) enc.push_back(blk[k]);
    endfunction

    function automatic void gen_frame(input int g, output bq_t enc);
        bq_t pl;
        int r = int'($urandom_range(0, 99));
        int len;
        if (r < 70) begin
            len = (g == 0 && r < 3) ? int'($urandom_range(250, 300))
                                    : int'($urandom_range(0, (g == 0) ? 24 : 7));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, (r < 3) ? 49 : 3) == 0) pl.push_back(8'h00);
                else pl.push_back(8'($urandom_range(1, 255)));
            end
            cobs_encode(pl, enc);
        end else begin
            enc.delete();
            len = int'($urandom_range(1, (g == 0) ? 12 : 8));
            for (int k = 0; k < len; k++) enc.push_back(8'($urandom_range(1, 255)));
        end
    endfunction

    task automatic send_byte(input int g, input logic [7:0] b);
        bit acc = 1'b0;
        if (rnd_val[g] && $urandom_range(0, 2) == 0) begin
            s_valid[g] = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        s_data[g]  = b;
        s_valid[g] = 1'b1;
        for (int t = 0; t < 2000 && !acc; t++) begin
            @(negedge clk);
            acc = s_ready[g];
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL dut%0d input_stall got tready=0 want 1 within 2000 cycles", g);
        end
    endtask

    task automatic send_frame(input int g, input bq_t enc);
        bq_t out;
        bit bad;
        beat_t b;
        ref_decode(enc, max_len(g), out, bad);
        foreach (out[k]) begin
            b.d = out[k];
            b.l = (k == out.size() - 1);
            b.u = b.l && bad;
            exp_push(g, b);
        end
        if (bad) exp_err[g]++;
        foreach (enc[k]) send_byte(g, enc[k]);
        send_byte(g, 8'h00);
        s_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g, input string tag);
        for (int t = 0; t < 20000 && exp_size(g) != 0; t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_beats_left"}, 32'(exp_size(g)), 32'd0);
        chk({tag, "_frame_errors"}, got_err[g], exp_err[g]);
    endtask

    task automatic zero_chk(input int g, input string tag);
        chk({tag, "_tvalid"}, 32'(m_valid[g]), 32'd0);
        chk({tag, "_tdata"}, 32'(m_data[g]), 32'd0);
        chk({tag, "_tlast"}, 32'(m_last[g]), 32'd0);
        chk({tag, "_tuser"}, 32'(m_user[g]), 32'd0);
        chk({tag, "_frame_error"}, 32'(ferr[g]), 32'd0);
        chk({tag, "_s_tready"}, 32'(s_ready[g]), 32'd0);
    endtask

    task automatic run_dut(input int g);
        bq_t f;
        if (g == 0) begin
            f = {8'h03, 8'h11, 8'h22, 8'h02, 8'h33};
            send_frame(0, f);
            drain(0, "basic");
            f = {8'h01, 8'h01};
            send_frame(0, f);
            f.delete();
            send_frame(0, f);
            send_frame(0, f);
            f = {8'h01};
            send_frame(0, f);
            drain(0, "zeros_empty");
            f.delete();
            f.push_back(8'hFF);
            for (int k = 1; k <= 254; k++) f.push_back(8'(k));
            send_frame(0, f);
            drain(0, "ff_block");
            f = {8'h04, 8'hAA};
            send_frame(0, f);
            f = {8'h02, 8'h55};
            send_frame(0, f);
            drain(0, "premature");
        end else begin
            f = {8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
            send_frame(1, f);
            drain(1, "overlength");
        end
        rnd_rdy[g] = 1'b1;
        rnd_val[g] = 1'b1;
        repeat ((g == 0) ? 200 : 120) begin
            gen_frame(g, f);
            send_frame(g, f);
        end
        drain(g, (g == 0) ? "random0" : "random1");
        rnd_rdy[g] = 1'b0;
        rnd_val[g] = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        bq_t f;
        reset = 1'b0;
        for (int g = 0; g < 2; g++) begin
            s_valid[g] = 1'b0;
            s_data[g]  = 8'h00;
            rnd_rdy[g] = 1'b0;
            rnd_val[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #2;
        zero_chk(0, "reset0");
        zero_chk(1, "reset1");
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        fork
            run_dut(0);
            run_dut(1);
        join

        // Reset in the middle of a frame: first byte already out, held byte must vanish.
        repeat (2) @(posedge clk);
        #1;
        exp_push(0, '{d: 8'h11, l: 1'b0, u: 1'b0});
        send_byte(0, 8'h05);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        s_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        zero_chk(0, "midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        f = {8'h03, 8'hAA, 8'hBB};
        send_frame(0, f);
        drain(0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_adapter_cobs_decoder.md
Name: axis_adapter_cobs_decoder

Overview:
Receive-side counterpart of the COBS encoder. It takes the raw UART RX byte stream, which holds COBS-encoded frames delimited by 0x00, and emits decoded payload bytes as an 8-bit AXI-Stream. `tlast` marks each frame end and `tuser` flags malformed frames. It sits between the UART `rx_stream` source and downstream command/packet consumers, in a single clock domain.

Parameters:
- MAX_FRAME_LEN, 256: maximum decoded payload bytes per frame. Longer frames are truncated and flagged.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset (0 = in reset). One clock; reset is asynchronous and active-low.
- s_axis_tdata, input, 8: encoded byte from the UART.
- s_axis_tvalid, input, 1: encoded byte valid.
- s_axis_tready, output, 1: decoder accepts a byte this cycle.
- m_axis_tdata, output, 8: decoded byte.
- m_axis_tvalid, output, 1: decoded byte valid.
- m_axis_tready, input, 1: downstream accepts.
- m_axis_tlast, output, 1: last decoded byte of a frame.
- m_axis_tuser, output, 1: qualifies tlast; 1 = frame malformed or truncated.
- frame_error, output, 1: one-cycle pulse per malformed, overlength or undecodable frame.

Behaviour:
- Reset (reset=0, async): state=CODE, block count=0, zero_owed=0, pend_valid=0, frame length=0.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, frame_error=0, s_axis_tready=0 while in reset.
  - A frame in progress at reset is lost; no partial output after release.
- Handshake:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready; this is a registered output stage.
  - An input byte is consumed when s_axis_tvalid && s_axis_tready.
  - Each consumed byte produces at most one decoded byte.
  - The m_axis output holds tdata/tlast/tuser stable while tvalid && !tready.
- One-byte holdback: each decoded byte is stored in a pend register. It moves to the m_axis register only when the next decoded byte or the delimiter arrives, so tlast is known when the byte is emitted.
- Latency: the decoded byte appears on m_axis the cycle after the following input byte is consumed. The last byte appears one cycle after the delimiter is consumed.
- State CODE, consumed byte b:
  - b=0x00: delimiter. If pend_valid, emit pend with tlast=1, tuser=0; otherwise the frame is empty and nothing is emitted (no error). zero_owed is cleared. Stay in CODE.
  - b≠0x00: if zero_owed, push 0x00 into pend (pend byte, if any, goes to output with tlast=0). Then set count=b-1 and zero_owed=(b≠0xFF). If count=0, stay in CODE; else go to DATA.
- State DATA, consumed byte b:
  - b≠0x00: push b into pend; count--. When count reaches 0, go to CODE.
  - b=0x00: premature delimiter. Emit pend with tlast=1, tuser=1 if pend_valid; pulse frame_error; clear zero_owed; go to CODE.
- Frame length counter, width $clog2(MAX_FRAME_LEN+1), counts bytes pushed into pend.
  - A push that would exceed MAX_FRAME_LEN emits pend with tlast=1, tuser=1, pulses frame_error, then enters DISCARD.
- State DISCARD: drop all bytes until 0x00 is consumed, then go to CODE. Nothing is emitted.
- The frame length counter resets on every delimiter and every error.
- Simultaneous events: a pend push and an m_axis transfer in the same cycle are legal; the output register reloads without a bubble.
- Delimiter handling: a delimiter while zero_owed=1 never emits the trailing zero.
- 0xFF blocks: a 0xFF code never owes a zero.

Decomposition:
- Shared package cobs_pkg (also used by the encoder): COBS_DELIM=8'h00, COBS_MAX_CODE=8'hFF, and the typedef enum cobs_dec_state_t {CODE, DATA, DISCARD}.
- No sub-module: the holdback and output register are simple enough to stay inline.

Test Plan:
1. Input 03 11 22 02 33 00 with tready=1 -> output 11 22 00 33; tlast only on 33; tuser=0; frame_error never asserted.
2. Input 01 01 00 -> single byte 00 with tlast=1. Input 00 00 and 01 00 -> no output, no frame_error.
3. Input FF, then 254 bytes 01..FE, then 00 -> exactly 254 bytes 01..FE; tlast on FE; no implicit zero.
4. Input 04 AA 00 -> byte AA with tlast=1, tuser=1; one frame_error pulse. A following 02 55 00 decodes cleanly to 55 with tlast, tuser=0.
5. With MAX_FRAME_LEN=4, input 06 01 02 03 04 05 00 -> 01 02 03 04, tuser=1 on 04; 05 dropped; one frame_error pulse.
6. Random m_axis_tready at 50% and random s_axis_tvalid over 200 frames checked against a reference decoder -> bytes, tlast and tuser match with no loss or duplication. Drive reset=0 mid-frame -> outputs zero immediately, and the next frame after release decodes correctly.
